// File: rtl/ttc_count_rst_multi.sv
// Per-channel clock control register, restart edge detect and power-of-two
// prescaler producing the registered count-enable strobe for each TTC counter.
module ttc_count_rst_multi #(
  parameter int NUM_CH   = 3,
  parameter int CTRL_W   = 7,
  parameter int PS_SEL_W = 4
) (
  input  logic                     pclk,
  input  logic                     p_reset,
  input  logic [CTRL_W-1:0]        pwdata,
  input  logic [NUM_CH-1:0]        clk_ctrl_reg_sel,
  input  logic [NUM_CH-1:0]        restart,
  output logic [NUM_CH-1:0]        count_en_out,
  output logic [NUM_CH*CTRL_W-1:0] clk_ctrl_reg_out
);

  localparam int PS_CNT_W = 2**PS_SEL_W;
  localparam logic [PS_CNT_W:0]   TERM_ONE = (PS_CNT_W+1)'(1);
  localparam logic [PS_CNT_W-1:0] CNT_ONE  = PS_CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CTRL_W-1:0]   clk_ctrl_reg;
    logic                restart_var;
    logic [PS_CNT_W-1:0] ps_cnt;
    logic                count_en;
    logic                ps_en;
    logic [PS_SEL_W-1:0] ps_sel;
    logic                restart_rise;
    logic                sync_ev;
    logic [PS_CNT_W:0]   term;

    assign ps_en        = clk_ctrl_reg[0];
    assign ps_sel       = clk_ctrl_reg[PS_SEL_W:1];
    assign restart_rise = restart[i] & ~restart_var;
    assign sync_ev      = restart_rise | clk_ctrl_reg_sel[i];

    // N = 2**(ps_sel+1) only fits in PS_CNT_W+1 bits; T = N-1 always fits ps_cnt
    assign term = ((TERM_ONE << ps_sel) << 1) - TERM_ONE;

    always_ff @(posedge pclk) begin
      if (p_reset) begin
        clk_ctrl_reg <= '0;
        restart_var  <= 1'b0;
        ps_cnt       <= '0;
        count_en     <= 1'b0;
      end else begin
        if (clk_ctrl_reg_sel[i]) begin
          clk_ctrl_reg <= pwdata;
        end
        restart_var <= restart_rise | (restart[i] & restart_var);

        if (sync_ev) begin
          ps_cnt   <= '0;
          count_en <= 1'b0;
        end else if (!ps_en) begin
          ps_cnt   <= '0;
          count_en <= 1'b1;
        end else if ({1'b0, ps_cnt} == term) begin
          ps_cnt   <= '0;
          count_en <= 1'b1;
        end else begin
          ps_cnt   <= ps_cnt + CNT_ONE;
          count_en <= 1'b0;
        end
      end
    end

    assign count_en_out[i]                        = count_en;
    assign clk_ctrl_reg_out[i*CTRL_W +: CTRL_W]   = clk_ctrl_reg;
  end

endmodule
